// File: rtl/pwm_adc_trigger.sv
// ============================================================================
// pwm_adc_trigger : decimated, delayed ADC start request from the PWM overflow
// Revision        : 1.0
// ============================================================================
`default_nettype none

module pwm_adc_trigger (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ovf_trigger,
  input  logic [7:0]  decim,
  input  logic [31:0] delay,
  input  logic [31:0] timeout,
  input  logic        adc_done,
  output logic        adc_start,
  output logic        busy,
  output logic [15:0] sample_id,
  output logic        timeout_err,
  output logic [15:0] missed_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ovf_d;
  logic [7:0]  dec_cnt;
  logic [31:0] dly_cnt;
  logic [31:0] tmo_cnt;

  logic        trig_event;
  logic        accept;
  logic        load_dly;
  logic        done_hit;
  logic        tmo_hit;

  assign trig_event = ovf_trigger & ~ovf_d & enable;
  assign accept     = trig_event && (dec_cnt == 8'd0);

  assign adc_start  = (state == S_START);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_dly  = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_nxt = S_DELAY;
            load_dly  = 1'b1;
          end
        end
        S_DELAY: begin
          if (dly_cnt == 32'd0) state_nxt = S_START;
        end
        S_START: begin
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (adc_done) begin
            state_nxt = S_IDLE;
            done_hit  = 1'b1;
          end else if (tmo_cnt == 32'd0) begin
            state_nxt = S_IDLE;
            tmo_hit   = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Reset value of 1 suppresses a spurious event from a trigger already high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_d <= 1'b1;
    end else begin
      ovf_d <= ovf_trigger;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      dec_cnt <= 8'd0;
    end else if (trig_event) begin
      if (dec_cnt == 8'd0) dec_cnt <= decim;
      else                 dec_cnt <= dec_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_cnt <= 32'd0;
      tmo_cnt <= 32'd0;
    end else begin
      if (load_dly) begin
        dly_cnt <= delay;
      end else if (state == S_DELAY && dly_cnt != 32'd0) begin
        dly_cnt <= dly_cnt - 32'd1;
      end
      if (state == S_START) begin
        tmo_cnt <= timeout;
      end else if (state == S_WAIT && tmo_cnt != 32'd0) begin
        tmo_cnt <= tmo_cnt - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_id    <= 16'd0;
      timeout_err  <= 1'b0;
      missed_count <= 16'd0;
    end else begin
      timeout_err <= tmo_hit;
      if (done_hit) sample_id <= sample_id + 16'd1;
      // Accepted events arriving while a conversion is in flight are dropped.
      if (accept && state != S_IDLE && missed_count != 16'hFFFF) begin
        missed_count <= missed_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_adc_trigger.sv
// ============================================================================
// tb_pwm_adc_trigger : scoreboard bench, directed vectors for pwm_adc_trigger
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_adc_trigger;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ovf_trigger;
  logic [7:0]  decim;
  logic [31:0] delay;
  logic [31:0] timeout;
  logic        adc_done;
  logic        adc_start;
  logic        busy;
  logic [15:0] sample_id;
  logic        timeout_err;
  logic [15:0] missed_count;

  pwm_adc_trigger dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ovf_trigger  (ovf_trigger),
    .decim        (decim),
    .delay        (delay),
    .timeout      (timeout),
    .adc_done     (adc_done),
    .adc_start    (adc_start),
    .busy         (busy),
    .sample_id    (sample_id),
    .timeout_err  (timeout_err),
    .missed_count (missed_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] val;
  } sid_exp_t;

  int       start_q[$];
  int       tmo_q[$];
  sid_exp_t sid_q[$];

  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  logic [15:0] prev_sid = 16'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (mon_on) begin
      if (adc_start) begin
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL adc_start_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          check("adc_start_cycle", cyc, start_q.pop_front());
        end
      end
      if (timeout_err) begin
        if (tmo_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL timeout_err_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          check("timeout_err_cycle", cyc, tmo_q.pop_front());
        end
      end
      if (sample_id != prev_sid) begin
        if (sid_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sample_id_unexpected: got %0d at cycle %0d expected %0d", sample_id, cyc, prev_sid);
        end else begin
          sid_exp_t s;
          s = sid_q.pop_front();
          check("sample_id_cycle", cyc, s.at);
          check("sample_id_value", int'(sample_id), int'(s.val));
        end
      end
      prev_sid = sample_id;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(output int e);
    e = cyc;
    ovf_trigger = 1'b1;
    @(negedge clk);
    ovf_trigger = 1'b0;
  endtask

  task automatic push_sid(input int at, input logic [15:0] val);
    sid_exp_t s;
    s.at  = at;
    s.val = val;
    sid_q.push_back(s);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int e;
    int e2;
    int base;
    int c;

    reset = 1'b1; enable = 1'b0; ovf_trigger = 1'b0; decim = 8'd0;
    delay = 32'd0; timeout = 32'd0; adc_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc_start", int'(adc_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sample_id", int'(sample_id), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_missed", int'(missed_count), 0);
    reset = 1'b0; enable = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);

    // Basic conversion with done
    decim = 8'd0; delay = 32'd5; timeout = 32'd100;
    pulse(e);
    start_q.push_back(e + 7);
    wait_until(e + 10);
    check("basic_busy_high", int'(busy), 1);
    adc_done = 1'b1;
    push_sid(e + 11, 16'd1);
    @(negedge clk);
    adc_done = 1'b0;
    check("basic_busy_low", int'(busy), 0);
    repeat (5) @(negedge clk);

    // Decimation by 3, each accepted conversion times out
    decim = 8'd2; timeout = 32'd20;
    base = cyc + 2;
    for (int k = 0; k < 9; k++) begin
      wait_until(base + 200 * k);
      pulse(e);
      if (k % 3 == 0) begin
        start_q.push_back(e + 7);
        tmo_q.push_back(e + 29);
      end
    end
    wait_until(base + 1800);
    check("decim_missed", int'(missed_count), 0);
    check("decim_sample_id", int'(sample_id), 1);

    // Timeout, then an immediate new event
    decim = 8'd0; delay = 32'd0; timeout = 32'd3;
    pulse(e);
    start_q.push_back(e + 2);
    tmo_q.push_back(e + 7);
    wait_until(e + 6);
    check("tmo_busy_last_wait", int'(busy), 1);
    @(negedge clk);
    check("tmo_busy_low", int'(busy), 0);
    check("tmo_sample_id", int'(sample_id), 1);
    pulse(e2);
    start_q.push_back(e2 + 2);
    tmo_q.push_back(e2 + 7);
    wait_until(e2 + 10);

    // Overlap: second event during DELAY is dropped
    delay = 32'd50;
    pulse(e);
    start_q.push_back(e + 52);
    tmo_q.push_back(e + 57);
    wait_until(e + 20);
    pulse(e2);
    check("overlap_missed_1", int'(missed_count), 1);
    wait_until(e + 60);
    force dut.missed_count = 16'hFFFF;
    @(negedge clk);
    release dut.missed_count;
    @(negedge clk);
    pulse(e);
    start_q.push_back(e + 52);
    tmo_q.push_back(e + 57);
    wait_until(e + 20);
    pulse(e2);
    check("overlap_missed_sat", int'(missed_count), 16'hFFFF);
    wait_until(e + 60);
    check("overlap_missed_hold", int'(missed_count), 16'hFFFF);

    // Level trigger held for 3 cycles gives one event
    delay = 32'd0; timeout = 32'd3;
    e = cyc;
    ovf_trigger = 1'b1;
    start_q.push_back(e + 2);
    tmo_q.push_back(e + 7);
    wait_until(e + 3);
    ovf_trigger = 1'b0;
    wait_until(e + 10);

    // Trigger held high through reset release
    c = cyc;
    ovf_trigger = 1'b1;
    reset = 1'b1;
    push_sid(c + 1, 16'd0);
    wait_until(c + 2);
    check("lvl_rst_missed", int'(missed_count), 0);
    reset = 1'b0;
    wait_until(c + 8);
    check("lvl_no_event_busy", int'(busy), 0);
    ovf_trigger = 1'b0;
    @(negedge clk);
    pulse(e);
    start_q.push_back(e + 2);
    tmo_q.push_back(e + 7);
    wait_until(e + 10);

    // Abort during DELAY
    delay = 32'd10; timeout = 32'd50;
    pulse(e);
    wait_until(e + 4);
    check("abort_dly_busy_before", int'(busy), 1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_dly_busy", int'(busy), 0);
    enable = 1'b1;
    wait_until(e + 20);

    // Abort during WAIT; a coincident done is not counted
    delay = 32'd0;
    pulse(e);
    start_q.push_back(e + 2);
    wait_until(e + 5);
    enable = 1'b0;
    adc_done = 1'b1;
    @(negedge clk);
    check("abort_wait_busy", int'(busy), 0);
    check("abort_wait_sample_id", int'(sample_id), 0);
    enable = 1'b1;
    adc_done = 1'b0;
    repeat (4) @(negedge clk);

    // Normal done, then reset mid-WAIT
    pulse(e);
    start_q.push_back(e + 2);
    wait_until(e + 4);
    adc_done = 1'b1;
    push_sid(e + 5, 16'd1);
    @(negedge clk);
    adc_done = 1'b0;
    check("done2_sample_id", int'(sample_id), 1);
    repeat (2) @(negedge clk);
    pulse(e);
    start_q.push_back(e + 2);
    wait_until(e + 4);
    check("rstw_busy_before", int'(busy), 1);
    reset = 1'b1;
    push_sid(e + 5, 16'd0);
    @(negedge clk);
    check("rstw_adc_start", int'(adc_start), 0);
    check("rstw_busy", int'(busy), 0);
    check("rstw_sample_id", int'(sample_id), 0);
    check("rstw_timeout_err", int'(timeout_err), 0);
    check("rstw_missed", int'(missed_count), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    check("pending_adc_start", start_q.size(), 0);
    check("pending_timeout_err", tmo_q.size(), 0);
    check("pending_sample_id", sid_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
